pipe_output_credit_fifo: RTL and testbench

//  Consumer-side stage for the generated valid-only pipelines: `__my_module__main` has no

---
 rtl/pipe_stream_pkg.sv | 21 ++
 rtl/sync_fifo_showahead.sv | 80 ++++++++
 rtl/pipe_output_credit_fifo.sv | 83 ++++++++
 tb/tb_pipe_output_credit_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stream_pkg.sv
// Shared defaults and width helpers for the valid-only pipeline output stage.
// Both the FIFO and the credit wrapper derive their counter widths from here.
package pipe_stream_pkg;

   localparam int WIDTH_DEFAULT        = 32;
   localparam int DEPTH_DEFAULT        = 4;
   localparam int PIPE_LATENCY_DEFAULT = 2;
   localparam int CNT_W_DEFAULT        = $clog2(DEPTH_DEFAULT + 1);

   typedef logic [WIDTH_DEFAULT-1:0] data_t;

   // Counter must hold the value DEPTH itself, hence DEPTH+1 states.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/sync_fifo_showahead.sv
// Show-ahead synchronous FIFO with explicit pointer wrap (any DEPTH >= 2).
// Drops a write that finds the FIFO full with no pop and raises a sticky overflow.
module sync_fifo_showahead
   import pipe_stream_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEFAULT,
   parameter  int DEPTH = DEPTH_DEFAULT,
   localparam int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] occupancy,
   output logic             overflow
);

   localparam int PTR_W = ptr_width(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_overflow;

   logic w_full;
   logic w_push;
   logic w_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign w_full = (r_count == CNT_W'(DEPTH));
   assign w_pop  = (r_count != '0) && out_ready;
   // A pop frees the slot in the same edge, so a full FIFO still accepts.
   assign w_push = in_valid && (!w_full || w_pop);

   // NOTE: storage carries no reset; the count alone decides what is valid,
   // and leaving the array unreset lets it map onto plain RAM/flop banks.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // NOTE: every register here uses <= so all updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
         if (in_valid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign out_valid = (r_count != '0);
   assign out_data  = r_mem[r_rd_ptr];
   assign occupancy = r_count;
   assign overflow  = r_overflow;

endmodule

// File: rtl/pipe_output_credit_fifo.sv
// Consumer-side stage for a no-backpressure pipeline: result FIFO plus an
// in-flight credit gate so the issuer never starts work without a free slot.
module pipe_output_credit_fifo
   import pipe_stream_pkg::*;
#(
   parameter  int WIDTH        = WIDTH_DEFAULT,
   parameter  int DEPTH        = DEPTH_DEFAULT,
   parameter  int PIPE_LATENCY = PIPE_LATENCY_DEFAULT,
   localparam int CNT_W        = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   output logic             issue_ok,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] occupancy,
   output logic             overflow,
   output logic             proto_err
);

   // PIPE_LATENCY only bounds how many results can be in flight; no logic uses it.
   if (DEPTH < 2 || PIPE_LATENCY < 1) begin : g_param_check
      $error("pipe_output_credit_fifo: DEPTH must be >= 2 and PIPE_LATENCY >= 1");
   end

   logic [CNT_W-1:0] r_inflight;
   logic             r_proto_err;

   logic [CNT_W:0]   w_credit_sum;
   logic             w_at_zero;
   logic             w_at_max;
   logic             w_issue_err;
   logic             w_underflow;
   logic             w_saturate;

   sync_fifo_showahead #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .occupancy (occupancy),
      .overflow  (overflow)
   );

   // Registers only: the issuer may look at issue_ok before deciding issue_valid.
   assign w_credit_sum = {1'b0, occupancy} + {1'b0, r_inflight};
   assign issue_ok     = (w_credit_sum < (CNT_W+1)'(DEPTH));

   assign w_at_zero   = (r_inflight == '0);
   assign w_at_max    = (r_inflight == '1);
   assign w_issue_err = issue_valid && !issue_ok;
   assign w_underflow = in_valid && w_at_zero;
   assign w_saturate  = issue_valid && !in_valid && w_at_max;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_inflight  <= '0;
         r_proto_err <= 1'b0;
      end else begin
         if (w_issue_err || w_underflow || w_saturate) begin
            r_proto_err <= 1'b1;
         end
         if (issue_valid && !in_valid && !w_at_max) begin
            r_inflight <= r_inflight + CNT_W'(1);
         end else if (in_valid && !issue_valid && !w_at_zero) begin
            r_inflight <= r_inflight - CNT_W'(1);
         end
      end
   end

   assign proto_err = r_proto_err;

endmodule

// File: tb/tb_pipe_output_credit_fifo.sv
// Directed + randomized bench: DEPTH=4 and DEPTH=3 instances share stimulus and
// are each compared every cycle against a queue-based reference model.
module tb_pipe_output_credit_fifo;
   import pipe_stream_pkg::*;

   typedef data_t word_t;

   logic  clk = 1'b0;
   logic  rst = 1'b0;
   logic  issue_valid = 1'b0;
   logic  in_valid = 1'b0;
   logic  out_ready = 1'b0;
   word_t in_data = '0;

   logic       a_ok, a_ov, a_ovf, a_perr;
   word_t      a_od;
   logic [2:0] a_occ;
   logic       b_ok, b_ov, b_ovf, b_perr;
   word_t      b_od;
   logic [1:0] b_occ;

   pipe_output_credit_fifo #(.WIDTH(32), .DEPTH(4), .PIPE_LATENCY(2)) u_dut4 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ok(a_ok),
      .in_valid(in_valid), .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready),
      .out_data(a_od), .occupancy(a_occ), .overflow(a_ovf), .proto_err(a_perr)
   );

   pipe_output_credit_fifo #(.WIDTH(32), .DEPTH(3), .PIPE_LATENCY(2)) u_dut3 (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ok(b_ok),
      .in_valid(in_valid), .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready),
      .out_data(b_od), .occupancy(b_occ), .overflow(b_ovf), .proto_err(b_perr)
   );

   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_err = 0;
   string phase = "init";

   // Reference model: a queue of stored words plus an in-flight count per instance.
   word_t mq0[$];
   word_t mq1[$];
   int    m_infl[2]  = '{0, 0};
   bit    m_ovf[2]   = '{0, 0};
   bit    m_perr[2]  = '{0, 0};
   int    m_depth[2] = '{4, 3};
   int    m_imax[2]  = '{7, 3};   // 2**clog2(DEPTH+1) - 1

   // Emulated 2-stage valid-only pipeline feeding in_valid/in_data.
   bit    p_v[2] = '{0, 0};
   word_t p_d[2] = '{0, 0};
   bit    pipe_en = 1'b1;

   function automatic int q_size(input int k);
      if (k == 0) return mq0.size();
      return mq1.size();
   endfunction

   function automatic word_t q_head(input int k);
      if (k == 0) return mq0[0];
      return mq1[0];
   endfunction

   function automatic bit model_ok(input int k);
      return (q_size(k) + m_infl[k]) < m_depth[k];
   endfunction

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int sz;
         bit pop;
         sz  = q_size(k);
         pop = (sz != 0) && out_ready;
         if (!rst) begin
            if (k == 0) mq0.delete(); else mq1.delete();
            m_infl[k] = 0;
            m_ovf[k]  = 0;
            m_perr[k] = 0;
         end else begin
            if (issue_valid && !model_ok(k)) m_perr[k] = 1;
            if (in_valid && m_infl[k] == 0) m_perr[k] = 1;
            if (issue_valid && !in_valid) begin
               if (m_infl[k] == m_imax[k]) m_perr[k] = 1;
               else m_infl[k]++;
            end else if (in_valid && !issue_valid && m_infl[k] > 0) begin
               m_infl[k]--;
            end
            if (pop) begin
               if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
            end
            if (in_valid) begin
               if (sz < m_depth[k] || pop) begin
                  if (k == 0) mq0.push_back(in_data); else mq1.push_back(in_data);
               end else begin
                  m_ovf[k] = 1;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      chk({phase, " d4.out_valid"}, word_t'(a_ov), word_t'(q_size(0) != 0));
      chk({phase, " d4.occupancy"}, word_t'(a_occ), word_t'(q_size(0)));
      chk({phase, " d4.issue_ok"}, word_t'(a_ok), word_t'(model_ok(0)));
      chk({phase, " d4.overflow"}, word_t'(a_ovf), word_t'(m_ovf[0]));
      chk({phase, " d4.proto_err"}, word_t'(a_perr), word_t'(m_perr[0]));
      if (q_size(0) != 0) chk({phase, " d4.out_data"}, a_od, q_head(0));
      chk({phase, " d3.out_valid"}, word_t'(b_ov), word_t'(q_size(1) != 0));
      chk({phase, " d3.occupancy"}, word_t'(b_occ), word_t'(q_size(1)));
      chk({phase, " d3.issue_ok"}, word_t'(b_ok), word_t'(model_ok(1)));
      chk({phase, " d3.overflow"}, word_t'(b_ovf), word_t'(m_ovf[1]));
      chk({phase, " d3.proto_err"}, word_t'(b_perr), word_t'(m_perr[1]));
      if (q_size(1) != 0) chk({phase, " d3.out_data"}, b_od, q_head(1));
   endtask

   // One clock: drive inputs, step the model at the edge, check at the falling edge.
   task automatic cycle(input bit iss, input word_t idat, input bit rdy,
                        input bit frc = 1'b0, input word_t fdat = '0);
      issue_valid = iss;
      out_ready   = rdy;
      in_valid    = p_v[1] | frc;
      in_data     = frc ? fdat : (p_v[1] ? p_d[1] : word_t'($urandom));
      @(posedge clk);
      model_step();
      if (!rst) begin
         p_v[0] = 1'b0;
         p_v[1] = 1'b0;
      end else begin
         p_v[1] = p_v[0];
         p_d[1] = p_d[0];
         p_v[0] = iss && pipe_en;
         p_d[0] = idat;
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      cycle(1'b0, '0, 1'b0);
      rst = 1'b1;
   endtask

   localparam word_t A = 32'hA0A0_0001;
   localparam word_t B = 32'hB0B0_0002;
   localparam word_t C = 32'hC0C0_0003;
   localparam word_t D = 32'hD0D0_0004;
   localparam word_t E = 32'hE0E0_0005;

   int    sent;
   int    guard;
   int    r;
   bit    go;
   word_t exp_tail[3];

   initial begin
      // Reset held 3 cycles with in_valid forced high.
      phase = "reset";
      rst = 1'b0;
      repeat (3) cycle(1'b0, '0, 1'b0, 1'b1, 32'h5555_5555);
      chk("reset d4.issue_ok", word_t'(a_ok), 32'd1);
      chk("reset d3.occupancy", word_t'(b_occ), 32'd0);
      rst = 1'b1;

      // Streaming 0x1..0x8 with out_ready=1, issuing only with credit on both.
      phase = "stream";
      sent  = 1;
      guard = 0;
      while (sent <= 8 && guard < 100) begin
         go = model_ok(0) && model_ok(1);
         cycle(go, word_t'(sent), 1'b1);
         if (go) sent++;
         guard++;
         chk("stream d4.occupancy<=1", word_t'(a_occ <= 3'd1), 32'd1);
      end
      chk("stream issue budget", word_t'(sent), 32'd9);
      repeat (4) cycle(1'b0, '0, 1'b1);

      // Credit gate on the DEPTH=4 instance.
      phase = "credit";
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 32'hC500 + word_t'(i), 1'b0);
         if (i == 2) chk("credit d4.issue_ok after 3rd", word_t'(a_ok), 32'd1);
      end
      chk("credit d4.issue_ok after 4th", word_t'(a_ok), 32'd0);
      repeat (2) cycle(1'b0, '0, 1'b0);
      chk("credit d4.occupancy full", word_t'(a_occ), 32'd4);
      chk("credit d4.issue_ok full", word_t'(a_ok), 32'd0);
      cycle(1'b0, '0, 1'b1);
      chk("credit d4.issue_ok after pop", word_t'(a_ok), 32'd1);

      // Full FIFO: simultaneous push and pop.
      phase = "fullpp";
      pulse_reset();
      cycle(1'b1, A, 1'b0);
      cycle(1'b1, B, 1'b0);
      cycle(1'b1, C, 1'b0);
      cycle(1'b1, D, 1'b0);
      repeat (2) cycle(1'b0, '0, 1'b0);
      chk("fullpp d4.head A", a_od, A);
      cycle(1'b0, '0, 1'b1, 1'b1, E);
      chk("fullpp d4.occupancy", word_t'(a_occ), 32'd4);
      chk("fullpp d4.overflow", word_t'(a_ovf), 32'd0);
      chk("fullpp d4.head B", a_od, B);
      exp_tail = '{C, D, E};
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, 1'b1);
         chk("fullpp d4.drain", a_od, exp_tail[i]);
      end
      cycle(1'b0, '0, 1'b1);
      chk("fullpp d4.empty", word_t'(a_ov), 32'd0);

      // Illegal issue then overflow; both flags sticky until reset.
      phase = "flags";
      pulse_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'hF000 + word_t'(i), 1'b0);
      repeat (2) cycle(1'b0, '0, 1'b0);
      pipe_en = 1'b0;
      cycle(1'b1, '0, 1'b0);
      pipe_en = 1'b1;
      chk("flags d4.proto_err", word_t'(a_perr), 32'd1);
      chk("flags d4.overflow before", word_t'(a_ovf), 32'd0);
      cycle(1'b0, '0, 1'b0, 1'b1, 32'h0000_DEAD);
      chk("flags d4.overflow", word_t'(a_ovf), 32'd1);
      chk("flags d4.head kept", a_od, 32'hF000);
      repeat (3) cycle(1'b0, '0, 1'b1);
      chk("flags d4.overflow sticky", word_t'(a_ovf), 32'd1);
      pulse_reset();
      chk("flags d4.cleared", word_t'({a_ovf, a_perr}), 32'd0);

      // Wrap on DEPTH=3: 10 legal words with random ready, then drain.
      phase = "wrap";
      sent  = 0;
      guard = 0;
      while (sent < 10 && guard < 200) begin
         go = model_ok(0) && model_ok(1);
         cycle(go, $urandom, 1'($urandom_range(0, 2) != 0));
         if (go) sent++;
         guard++;
      end
      chk("wrap issue budget", word_t'(sent), 32'd10);
      repeat (8) cycle(1'b0, '0, 1'b1);
      chk("wrap d3.drained", word_t'(b_occ), 32'd0);

      // Reset with 2 stored and 2 in flight; flushed results never arrive.
      phase = "midrst";
      cycle(1'b1, 32'h1111, 1'b0);
      cycle(1'b1, 32'h2222, 1'b0);
      cycle(1'b1, 32'h3333, 1'b0);
      cycle(1'b1, 32'h4444, 1'b0);
      chk("midrst d4.stored 2", word_t'(a_occ), 32'd2);
      pulse_reset();
      chk("midrst d4.occupancy", word_t'(a_occ), 32'd0);
      chk("midrst d4.issue_ok", word_t'(a_ok), 32'd1);
      repeat (4) cycle(1'b0, '0, 1'b0);
      chk("midrst d4.no arrivals", word_t'(a_occ), 32'd0);

      // In-flight saturation: issues with no results, then excess results.
      phase = "sat";
      pipe_en = 1'b0;
      repeat (10) cycle(1'b1, '0, 1'b0);
      pipe_en = 1'b1;
      repeat (5) cycle(1'b0, '0, 1'b1, 1'b1, $urandom);
      repeat (2) cycle(1'b0, '0, 1'b1);
      pulse_reset();

      // Randomized mix: mostly legal traffic, occasional violations and resets.
      phase = "random";
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            pulse_reset();
         end else begin
            go = (r < 5) || (model_ok(0) && model_ok(1) && r < 65);
            cycle(go, $urandom, 1'($urandom_range(0, 3) != 0), 1'(r >= 97), $urandom);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
